// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA multiplier sharing logic and the S_multi benches.
package rsa_pkg;
  localparam int DEF_BIT  = 8;
  localparam int DEF_NREQ = 2;
  localparam int PACK_W   = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // {hreg[bitw-1:0], lreg[bitw-1:0]}; callers zero-extend to PACK_W and slice 2*bitw.
  function automatic logic [2*PACK_W-1:0] pack_prod(input logic [PACK_W-1:0] hreg,
                                                    input logic [PACK_W-1:0] lreg,
                                                    input int unsigned       bitw);
    logic [2*PACK_W-1:0] mask;
    mask = ({{(2*PACK_W-1){1'b0}}, 1'b1} << bitw) - {{(2*PACK_W-1){1'b0}}, 1'b1};
    return (({{PACK_W{1'b0}}, hreg} & mask) << bitw) | ({{PACK_W{1'b0}}, lreg} & mask);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!found && req[(int'(ptr) + off) % NREQ]) begin
        found = 1'b1;
        gnt[(int'(ptr) + off) % NREQ] = 1'b1;
        idx = IW'((int'(ptr) + off) % NREQ);
      end
    end
  end
endmodule

// File: rtl/mult_arbiter.sv
// Shares one shift-add multiplier between NREQ requesters, round-robin.
// MULT_TIMEOUT_EN adds a RUN watchdog and the sticky err output.
module mult_arbiter
  import rsa_pkg::*;
#(
  parameter int BIT     = DEF_BIT,
  parameter int NREQ    = DEF_NREQ,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*BIT-1:0] a_in,
  input  logic [NREQ*BIT-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*BIT-1:0]  prod,
`ifdef MULT_TIMEOUT_EN
  output logic              err,
`endif
  output logic              m_start,
  input  logic              m_busy,
  output logic [BIT-1:0]    m_a,
  output logic [BIT-1:0]    m_b,
  input  logic [BIT:0]      m_hreg,
  input  logic [BIT-1:0]    m_lreg
);
  localparam int IW = $clog2(NREQ);

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, win_idx, arb_idx;
  logic [NREQ-1:0] arb_gnt;
  logic            run_end;
  logic [2*PACK_W-1:0] packed_w;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // m_hreg[BIT] is the adder carry-out slot and never part of the product.
  assign packed_w = pack_prod(PACK_W'(m_hreg[BIT-1:0]), PACK_W'(m_lreg), BIT);

`ifdef MULT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  assign tmo_hit = m_busy && (tmo_cnt == TW'(TIMEOUT - 1));
  assign run_end = !m_busy || tmo_hit;
`else
  assign run_end = !m_busy;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (|req && !m_busy) state_nx = S_START;
      S_START: state_nx = S_ARM;
      S_ARM:   state_nx = S_RUN;
      S_RUN:   if (run_end) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign m_start = (state == S_START);
  assign done    = (state == S_DONE) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      prod    <= '0;
      m_a     <= '0;
      m_b     <= '0;
      ptr     <= IW'(NREQ - 1);
      win_idx <= '0;
`ifdef MULT_TIMEOUT_EN
      err     <= 1'b0;
      tmo_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (state_nx == S_START) begin
          gnt     <= arb_gnt;
          win_idx <= arb_idx;
          m_a     <= a_in[arb_idx*BIT +: BIT];
          m_b     <= b_in[arb_idx*BIT +: BIT];
        end
`ifdef MULT_TIMEOUT_EN
        S_ARM: tmo_cnt <= '0;
        S_RUN: begin
          if (!m_busy) prod <= packed_w[2*BIT-1:0];
          else if (tmo_hit) begin
            prod <= '0;
            err  <= 1'b1;
          end else tmo_cnt <= tmo_cnt + 1'b1;
        end
`else
        S_RUN: if (!m_busy) prod <= packed_w[2*BIT-1:0];
`endif
        S_DONE: begin
          gnt <= '0;
          ptr <= win_idx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one S_multi shift-add multiplier between NREQ requesters, e.g. the encrypt and decrypt datapaths of the RSA core.
- Captures the winner's operands, pulses the multiplier start, and waits out busy.
- Returns the 2*BIT product to the winner with a one-cycle done pulse.

Parameters:
- BIT, 8, operand width; the product is 2*BIT.
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 255, watchdog limit in cycles while in RUN. Used only with MULT_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; held high with operands stable until done.
- a_in  in  NREQ*BIT  packed operand A; slice i belongs to requester i.
- b_in  in  NREQ*BIT  packed operand B.
- gnt  out  NREQ  one-hot grant, high from START through DONE.
- done  out  NREQ  one-cycle pulse to the granted requester.
- prod  out  2*BIT  product; valid in the done cycle and held until the next capture.
- err  out  1  timeout flag, sticky until rst. Present only with MULT_TIMEOUT_EN.
- m_start  out  1  multiplier start.
- m_busy  in  1  multiplier busy.
- m_a, m_b  out  BIT  multiplier operands.
- m_hreg  in  BIT+1  multiplier high result.
- m_lreg  in  BIT  multiplier low result.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, gnt=0, done=0, prod=0, m_start=0, m_a=0, m_b=0, err=0.
  - RR pointer=NREQ-1, so requester 0 wins first.
- FSM states: IDLE, START, ARM, RUN, DONE.
- IDLE:
  - If any req=1 and m_busy=0, pick the first requesting index after the pointer, wrapping.
  - Register m_a/m_b from that requester's slice, set gnt, go to START.
  - If m_busy=1 (multiplier still busy from a pre-reset operation), stay in IDLE.
- START: m_start=1 for exactly this one cycle; go to ARM.
- ARM: one cycle in which m_busy is ignored, covering the busy rise latency; go to RUN.
- RUN: stay while m_busy=1. When m_busy=0, capture prod={m_hreg[BIT-1:0], m_lreg} and go to DONE. m_hreg[BIT] is discarded.
- DONE:
  - done[winner]=1 for one cycle.
  - Pointer := winner, gnt cleared, go to IDLE.
- Operands: m_a/m_b are held constant from START until IDLE is re-entered. Changes on a_in/b_in after capture are ignored.
- Latency: req seen in IDLE at cycle 0 → m_start at cycle 1 → done at cycle 3+N, where N is the number of cycles busy stays high.
- Back-to-back requests:
  - Minimum gap between two done pulses is 4+N cycles (IDLE revisited once).
  - If the winner keeps req high after done, it is a new request. Any other pending requester wins first.
- Dropped request: req dropping while granted is ignored; the operation completes and done still pulses.
- Reset mid-operation: the FSM returns to IDLE next cycle with all outputs at reset values. An in-flight multiply is abandoned, and the IDLE m_busy check prevents overlap with it.
- Simultaneous req and rst: rst wins.

Optional Feature:
- Macro: MULT_TIMEOUT_EN.
- Defined:
  - A counter clears on entering RUN and increments each RUN cycle.
  - When it reaches TIMEOUT, go to DONE with prod=0 and set err=1 (sticky until rst). done still pulses.
- Undefined: no counter and no err port; RUN waits indefinitely.

Decomposition:
- Shared package rsa_pkg:
  - FSM state encodings (3-bit localparams).
  - Default BIT and NREQ.
  - The product packing function {hreg[BIT-1:0], lreg}, shared with the S_multi benches.
- One sub-module, rr_arbiter (NREQ):
  - Inputs: req and the pointer.
  - Output: one-hot grant plus its index.
  - Purely combinational, instantiated once.

Test Plan:
- req[0]=1, A=0x11, B=0x02 → one m_start pulse, gnt=01, done[0] pulse, prod=0x0022.
- req=11 in the same cycle, req0 with 0xFF*0xFF and req1 with 0x01*0x00 → req0 served first with prod=0xFE01, then req1 with prod=0x0000; gnt never two-hot.
- Both requesters hold req for 4 operations → grants alternate 0,1,0,1; each done lands only on the matching gnt.
- rst asserted during RUN → next cycle gnt=0 and m_start=0, no done pulse; a new req waits until m_busy=0, then completes correctly (0x03*0x05 → 0x000F).
- Edge operands 0x01*0x01 and 0x00*0x01 → prod 0x0001 and 0x0000; each product matches A*B.
- MULT_TIMEOUT_EN with TIMEOUT=16 and m_busy forced high → done pulses 16 RUN cycles after entering RUN, with prod=0 and err=1 until rst.
